ins_line_refill_unit: RTL

//  Services instruction-cache miss requests on the L2-side handshake and returns full cache lines.

---
 rtl/ins_line_refill_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ins_line_refill_unit.sv
// Instruction-cache line refill: fetches a full line as single-beat reads on a narrow memory bus.
// Optional macro INS_REFILL_LINE_REUSE_EN re-serves the last delivered line on a tag hit.
module ins_line_refill_unit #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int L2_BUS_WIDTH  = 512,
   parameter int MEM_BUS_WIDTH = 64
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       ADDRESS_TO_L2_VALID_INS,
   output logic                       ADDRESS_TO_L2_READY_INS,
   input  logic [ADDRESS_WIDTH-3:0]   ADDRESS_TO_L2_INS,
   output logic                       DATA_FROM_L2_VALID_INS,
   input  logic                       DATA_FROM_L2_READY_INS,
   output logic [L2_BUS_WIDTH-1:0]    DATA_FROM_L2_INS,
   output logic                       MEM_REQ_VALID,
   input  logic                       MEM_REQ_READY,
   output logic [ADDRESS_WIDTH-1:0]   MEM_REQ_ADDR,
   input  logic                       MEM_RESP_VALID,
   input  logic [MEM_BUS_WIDTH-1:0]   MEM_RESP_DATA
);

   localparam int BEATS      = L2_BUS_WIDTH / MEM_BUS_WIDTH;
   localparam int CNT_W      = $clog2(BEATS);
   localparam int TAG_W      = ADDRESS_WIDTH - 6;
   localparam int BEAT_BYTES = MEM_BUS_WIDTH / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DELIVER
   } state_t;

   state_t                    r_state;
   logic [CNT_W-1:0]          r_beat_cnt;
   logic [TAG_W-1:0]          r_tag;
   logic                      r_mem_req_valid;
   logic [ADDRESS_WIDTH-1:0]  r_mem_req_addr;
   logic                      r_data_valid;
   logic [L2_BUS_WIDTH-1:0]   r_line;

   logic [TAG_W-1:0]          w_req_tag;
   logic                      w_accept;
   logic                      w_hit;
   logic                      w_last_beat;
   logic [CNT_W-1:0]          w_beat_nxt;
   logic [ADDRESS_WIDTH-1:0]  w_next_addr;
   logic                      w_unused_word_ofs;

   // The word offset inside the line never affects the refill: beat 0 is always the line base.
   assign w_req_tag         = ADDRESS_TO_L2_INS[ADDRESS_WIDTH-3:4];
   assign w_unused_word_ofs = ^ADDRESS_TO_L2_INS[3:0];

   assign w_accept    = (r_state == S_IDLE) && ADDRESS_TO_L2_VALID_INS;
   assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));
   assign w_beat_nxt  = r_beat_cnt + CNT_W'(1);
   assign w_next_addr = {r_tag, 6'b0} + ADDRESS_WIDTH'(w_beat_nxt) * ADDRESS_WIDTH'(BEAT_BYTES);

   // Ready is a pure function of the state so a new request is taken on the very first IDLE cycle.
   assign ADDRESS_TO_L2_READY_INS = (r_state == S_IDLE) && !RST;
   assign DATA_FROM_L2_VALID_INS  = r_data_valid;
   assign DATA_FROM_L2_INS        = r_line;
   assign MEM_REQ_VALID           = r_mem_req_valid;
   assign MEM_REQ_ADDR            = r_mem_req_addr;

`ifdef INS_REFILL_LINE_REUSE_EN
   logic              r_reuse_valid;
   logic [TAG_W-1:0]  r_reuse_tag;

   // r_line already holds the last delivered line whenever the FSM is back in IDLE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_reuse_valid <= 1'b0;
         r_reuse_tag   <= '0;
      end else if (r_state == S_WAIT && MEM_RESP_VALID && w_last_beat) begin
         r_reuse_valid <= 1'b1;
         r_reuse_tag   <= r_tag;
      end
   end

   assign w_hit = r_reuse_valid && (r_reuse_tag == w_req_tag);
`else
   assign w_hit = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state         <= S_IDLE;
         r_beat_cnt      <= '0;
         r_tag           <= '0;
         r_mem_req_valid <= 1'b0;
         r_mem_req_addr  <= '0;
         r_data_valid    <= 1'b0;
         // NOTE: the line buffer is a plain register, so it is cleared with the rest of the state.
         r_line          <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every branch reading the pre-edge state.
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tag      <= w_req_tag;
                  r_beat_cnt <= '0;
                  if (w_hit) begin
                     r_state      <= S_DELIVER;
                     r_data_valid <= 1'b1;
                  end else begin
                     r_state         <= S_ISSUE;
                     r_mem_req_valid <= 1'b1;
                     r_mem_req_addr  <= {w_req_tag, 6'b0};
                  end
               end
            end
            S_ISSUE: begin
               if (MEM_REQ_READY) begin
                  r_state         <= S_WAIT;
                  r_mem_req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (MEM_RESP_VALID) begin
                  r_line[r_beat_cnt*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] <= MEM_RESP_DATA;
                  if (w_last_beat) begin
                     r_state      <= S_DELIVER;
                     r_data_valid <= 1'b1;
                  end else begin
                     r_beat_cnt      <= w_beat_nxt;
                     r_state         <= S_ISSUE;
                     r_mem_req_valid <= 1'b1;
                     r_mem_req_addr  <= w_next_addr;
                  end
               end
            end
            S_DELIVER: begin
               if (DATA_FROM_L2_READY_INS) begin
                  r_state      <= S_IDLE;
                  r_data_valid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
